// File: rtl/audio_pkg.sv
// Shared audio-path constants and the stereo sample type exchanged with the DSP core.
package audio_pkg;

  localparam int unsigned SAMPLE_BITS = 16;
  localparam int unsigned SLOT_BITS   = 48;
  localparam int unsigned FRAME_BITS  = 2 * SLOT_BITS;
  localparam int unsigned BCLK_HALF   = 2;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clock_gen.sv
// BCLK divider and frame bit counter; tick marks each BCLK falling edge.
module i2s_clock_gen #(
  parameter int unsigned SLOT_BITS = audio_pkg::SLOT_BITS,
  parameter int unsigned BCLK_HALF = audio_pkg::BCLK_HALF,
  parameter int unsigned CNT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             aud_bclk,
  output logic             tick,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             aud_daclrck
);

  localparam int unsigned      DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_START = CNT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign tick     = div_wrap && aud_bclk;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt     <= '0;
      aud_bclk    <= 1'b0;
      bit_cnt     <= '0;
      aud_daclrck <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt  <= '0;
        aud_bclk <= ~aud_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      // LRCK follows the pre-tick count, so it changes one BCLK after the count wraps.
      if (tick) begin
        bit_cnt     <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
        aud_daclrck <= (bit_cnt >= SLOT_START);
      end
    end
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// I2S serializer for the SSM2603 DAC: one-frame hold buffer, frame registers, bit select.
// SAMPLE_BITS must be smaller than SLOT_BITS.
module i2s_dac_serializer #(
  parameter int unsigned SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
  parameter int unsigned SLOT_BITS   = audio_pkg::SLOT_BITS,
  parameter int unsigned BCLK_HALF   = audio_pkg::BCLK_HALF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SAMPLE_BITS-1:0] sample_l,
  input  logic [SAMPLE_BITS-1:0] sample_r,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic                   mute,
  output logic                   aud_bclk,
  output logic                   aud_daclrck,
  output logic                   aud_dacdat,
  output logic                   frame_strobe,
  output logic [7:0]             underrun_count
);

  localparam int unsigned      CNT_W      = $clog2(2 * SLOT_BITS);
  localparam int unsigned      IDX_W      = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_START = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(SAMPLE_BITS);

  logic                   tick;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   hold_full;
  logic [SAMPLE_BITS-1:0] hold_l, hold_r;
  logic [SAMPLE_BITS-1:0] frame_l, frame_r;
  logic                   accept, load;
  logic [CNT_W-1:0]       slot_pos;
  logic [SAMPLE_BITS-1:0] chan;
  logic                   bit_next;

  i2s_clock_gen #(
    .SLOT_BITS (SLOT_BITS),
    .BCLK_HALF (BCLK_HALF),
    .CNT_W     (CNT_W)
  ) u_clock_gen (
    .clock       (clock),
    .reset       (reset),
    .aud_bclk    (aud_bclk),
    .tick        (tick),
    .bit_cnt     (bit_cnt),
    .aud_daclrck (aud_daclrck)
  );

  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;
  assign load         = tick && (bit_cnt == CNT_LAST);

  // Slot position p carries channel bit SAMPLE_BITS-p: MSB lands one BCLK after LRCK changes.
  always_comb begin
    slot_pos = (bit_cnt >= SLOT_START) ? bit_cnt - SLOT_START : bit_cnt;
    chan     = aud_daclrck ? frame_r : frame_l;
    bit_next = 1'b0;
    if (slot_pos >= CNT_W'(1) && slot_pos <= DATA_LAST)
      bit_next = chan[IDX_W'(DATA_LAST - slot_pos)];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full      <= 1'b0;
      hold_l         <= '0;
      hold_r         <= '0;
      frame_l        <= '0;
      frame_r        <= '0;
      aud_dacdat     <= 1'b0;
      frame_strobe   <= 1'b0;
      underrun_count <= '0;
    end else begin
      frame_strobe <= load;
      if (accept) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
      end
      // Load reads the pre-edge hold state; a same-cycle accept refills hold for the next frame.
      if (accept)
        hold_full <= 1'b1;
      else if (load)
        hold_full <= 1'b0;
      if (load) begin
        if (hold_full && !mute) begin
          frame_l <= hold_l;
          frame_r <= hold_r;
        end else begin
          frame_l <= '0;
          frame_r <= '0;
        end
        if (!hold_full && underrun_count != '1)
          underrun_count <= underrun_count + 8'd1;
      end
      if (tick)
        aud_dacdat <= bit_next;
    end
  end

endmodule
